ram_rr_controller: RTL
======================

// Module: ram_rr_controller
// PURPOSE
//   Sequencer/arbiter in front of the single-port synchronous RAM (DATA_WIDTH x MEM_DEPTH).
//   After reset, sweeps the RAM and writes every word to zero.
//   Then shares the RAM between two requesters (port A, port B) with round-robin priority.
//   One access is issued per cycle; read data returns with fixed latency.
// PARAMETERS
//   DATA_WIDTH  8    word width
//   ADDR_WIDTH  7    address width
//   MEM_DEPTH   128  words in RAM; <= 2**ADDR_WIDTH
// PORTS
//   clk          in   1           single clock, rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   a_valid      in   1           port A request valid
//   a_we         in   1           port A: 1=write, 0=read
//   a_addr       in   ADDR_WIDTH  port A address
//   a_wdata      in   DATA_WIDTH  port A write data
//   a_ready      out  1           port A request accepted this cycle
//   a_rvalid     out  1           port A read data valid
//   a_rdata      out  DATA_WIDTH  port A read data
//   b_*          --   --          identical set for port B
//   ram_we       out  1           to RAM we
//   ram_addr     out  ADDR_WIDTH  to RAM addr
//   ram_din      out  DATA_WIDTH  to RAM data_in
//   ram_dout     in   DATA_WIDTH  from RAM data_out (registered, 1-cycle)
//   init_done    out  1           high once the clear sweep has completed
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=INIT, init_cnt=0, rr_ptr=A, a/b_ready=0, a/b_rvalid=0, init_done=0
//     - ram_we=0, ram_addr=0, ram_din=0
//   FSM states:
//     - INIT: ram_we=1, ram_addr=init_cnt, ram_din=0; init_cnt++ each cycle.
//     - INIT -> RUN: after the write at addr MEM_DEPTH-1 (exactly MEM_DEPTH cycles).
//     - INIT: a/b_ready=0; incoming requests are held off, not dropped.
//     - RUN: init_done=1; remains in RUN until reset.
//   Handshake (RUN):
//     - Transfer occurs when x_valid && x_ready at a rising edge.
//     - ready is combinational from valid and rr_ptr; at most one of a_ready/b_ready is high.
//     - Requester holds valid/we/addr/wdata stable until ready.
//   Arbitration:
//     - Only one valid: that port is granted.
//     - Both valid: port == rr_ptr is granted.
//     - rr_ptr toggles to the other port after every grant, so A,B alternate under contention.
//   RAM drive:
//     - ram_we/addr/din are combinational from the granted request.
//     - No grant: ram_we=0.
//   Read latency:
//     - Read accepted at edge n: x_rvalid=1 during cycle n+1, x_rdata = ram_dout.
//     - Pipeline register holds {rd_pending, rd_port}.
//     - Only the issuing port sees rvalid; the other port's rdata is don't-care (driven 0).
//   Writes: no response; write at edge n is visible to any read accepted at edge n+1 or later.
//   Back-to-back: reads each cycle give rvalid each cycle; alternating ports give alternating rvalid.
//   Address >= MEM_DEPTH: access is forwarded unchanged; result undefined, no error flag.
//   Reset mid-operation:
//     - Any pending rvalid is dropped and the sweep restarts from address 0.
//     - RAM contents are cleared again.
// STRUCTURE
//   - Shared package/include ram_ctrl_pkg:
//       - state encoding ST_INIT/ST_RUN
//       - port ids PORT_A=0/PORT_B=1
//   - Sub-module rr_arb2: 2-way round-robin arbiter.
//       - In: req[1:0], advance. Out: one-hot gnt[1:0], internal rr_ptr.
//       - Async active-low reset, ptr=PORT_A.
//   - Top: INIT counter/FSM, request mux, one-deep read-return register.
// TESTING
//   1. Reset, no requests:
//        -> init_done rises exactly 128 cycles after rst_n deasserts
//        -> a read of addr 0x7F returns 0x00
//   2. During INIT, a_valid=1:
//        -> a_ready=0 until init_done; granted the first RUN cycle.
//   3. A writes 0x5A @0x10; next cycle B reads 0x10:
//        -> b_rvalid one cycle after accept, b_rdata=0x5A; a_rvalid stays 0.
//   4. A and B both valid (reads) for 6 cycles, fresh reset:
//        -> grants A,B,A,B,A,B; each port gets 3 rvalid pulses, 1-cycle latency.
//   5. Simultaneous A write 0x33@0x20 and B read @0x20, rr_ptr=A:
//        -> A granted first; B read next cycle returns 0x33.
//   6. Assert rst_n=0 while a read is pending:
//        -> rvalid=0 immediately; sweep restarts; previously written 0x5A@0x10 reads back 0x00.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM round-robin controller: FSM state encoding and port ids.
package ram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Returns the port that did not win, which is where priority moves after a grant.
    function automatic logic other_port(input logic [1:0] gnt);
        return gnt[0] ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/ram_rr_controller_arb.sv
// Two-way round-robin arbiter: one-hot grant, priority pointer moves away from each winner.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr_r;
    logic [1:0] gnt_s;

    // Grant decode: a lone requester wins, contention is settled by the pointer.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (rr_ptr_r == PORT_A) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    // Priority pointer update after every issued grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= PORT_A;
        end else if (advance && (gnt_s != 2'b00)) begin
            rr_ptr_r <= other_port(gnt_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/ram_rr_controller.sv
// Sequencer/arbiter in front of a single-port synchronous RAM: zero sweep after reset,
// then round-robin sharing between ports A and B with a one-cycle read return.
module ram_rr_controller
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   init_cnt_r;
    logic [1:0]              req_s;
    logic [1:0]              gnt_s;
    logic                    rd_issue_s;
    logic                    rd_pending_r;
    logic                    rd_port_r;
    logic                    ram_we_s;
    logic [ADDR_WIDTH-1:0]   ram_addr_s;
    logic [DATA_WIDTH-1:0]   ram_din_s;

    // Requests are only presented to the arbiter once the sweep is over, so they wait rather than drop.
    assign req_s = (state_r == ST_RUN) ? {b_valid, a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_s),
        .advance (1'b1),
        .gnt     (gnt_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave INIT after the write to the last word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Output logic: sweep writes in INIT, granted request drives the RAM in RUN.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = {ADDR_WIDTH{1'b0}};
        ram_din_s  = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_INIT: begin
                ram_we_s   = rst_n;
                ram_addr_s = init_cnt_r;
                ram_din_s  = {DATA_WIDTH{1'b0}};
            end
            ST_RUN: begin
                if (gnt_s[0]) begin
                    ram_we_s   = a_we;
                    ram_addr_s = a_addr;
                    ram_din_s  = a_wdata;
                end else if (gnt_s[1]) begin
                    ram_we_s   = b_we;
                    ram_addr_s = b_addr;
                    ram_din_s  = b_wdata;
                end else begin
                    ram_we_s   = 1'b0;
                    ram_addr_s = {ADDR_WIDTH{1'b0}};
                    ram_din_s  = {DATA_WIDTH{1'b0}};
                end
            end
            default: begin
                ram_we_s   = 1'b0;
                ram_addr_s = {ADDR_WIDTH{1'b0}};
                ram_din_s  = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Sweep address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + ADDR_ONE;
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    assign rd_issue_s = (gnt_s[0] & ~a_we) | (gnt_s[1] & ~b_we);

    // Read-return pipeline: remembers which port issued the read accepted last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
            rd_port_r    <= PORT_A;
        end else begin
            rd_pending_r <= rd_issue_s;
            rd_port_r    <= rd_issue_s ? gnt_s[1] : rd_port_r;
        end
    end

    assign a_ready   = gnt_s[0];
    assign b_ready   = gnt_s[1];
    assign a_rvalid  = rd_pending_r & (rd_port_r == PORT_A);
    assign b_rvalid  = rd_pending_r & (rd_port_r == PORT_B);
    assign a_rdata   = a_rvalid ? ram_dout : {DATA_WIDTH{1'b0}};
    assign b_rdata   = b_rvalid ? ram_dout : {DATA_WIDTH{1'b0}};
    assign ram_we    = ram_we_s;
    assign ram_addr  = ram_addr_s;
    assign ram_din   = ram_din_s;
    assign init_done = (state_r == ST_RUN);

endmodule
